// File: rtl/sbox_array_pipe.sv
// Multi-lane AES S-box / inverse S-box / raw GF(2^8) inverse using composite-field GF((2^4)^2) arithmetic.
// Latency 2 (+1 with CREATE_OUTPUT_REG) enabled cycles, 1 beat per enabled cycle; i_enable=0 freezes every stage.
module sbox_array_pipe #(
    parameter int NB_BYTE           = 8,
    parameter int N_LANES           = 16,
    parameter int NB_DATA           = N_LANES * NB_BYTE,
    parameter int CREATE_OUTPUT_REG = 0
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic [1:0]         i_mode,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_valid,
    output logic [1:0]         o_mode,
    output logic [NB_DATA-1:0] o_data
);

    function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
        return {(a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]), (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    // GF(2^4) built as GF(2^2)[x]/(x^2 + x + phi), phi = {10}
    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh, hi, lo;
        hh = gf2_mul(a[3:2], b[3:2]);
        hi = hh ^ gf2_mul(a[3:2], b[1:0]) ^ gf2_mul(a[1:0], b[3:2]);
        lo = {hh[1] ^ hh[0], hh[1]} ^ gf2_mul(a[1:0], b[1:0]);
        return {hi, lo};
    endfunction

    function automatic logic [3:0] gf4_sq(input logic [3:0] q);
        return {q[3], q[3] ^ q[2], q[2] ^ q[1], q[3] ^ q[1] ^ q[0]};
    endfunction

    function automatic logic [3:0] gf4_lambda(input logic [3:0] q);
        return {q[2] ^ q[0], q[3] ^ q[2] ^ q[1] ^ q[0], q[3], q[2]};
    endfunction

    function automatic logic [3:0] gf4_inv(input logic [3:0] q);
        logic [3:0] r;
        r[3] = q[3] ^ (q[3] & q[2] & q[1]) ^ (q[3] & q[0]) ^ q[2];
        r[2] = (q[3] & q[2] & q[1]) ^ (q[3] & q[2] & q[0]) ^ (q[3] & q[0]) ^ q[2] ^ (q[2] & q[1]);
        r[1] = q[3] ^ (q[3] & q[2] & q[1]) ^ (q[3] & q[1] & q[0]) ^ q[2] ^ (q[2] & q[0]) ^ q[1];
        r[0] = (q[3] & q[2] & q[1]) ^ (q[3] & q[2] & q[0]) ^ (q[3] & q[1]) ^ (q[3] & q[1] & q[0])
             ^ (q[3] & q[0]) ^ q[2] ^ (q[2] & q[1]) ^ (q[2] & q[1] & q[0]) ^ q[1] ^ q[0];
        return r;
    endfunction

    function automatic logic [7:0] iso_map(input logic [7:0] q);
        logic [7:0] r;
        r[7] = q[7] ^ q[5];
        r[6] = q[7] ^ q[6] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        r[5] = q[7] ^ q[5] ^ q[3] ^ q[2];
        r[4] = q[7] ^ q[5] ^ q[3] ^ q[2] ^ q[1];
        r[3] = q[7] ^ q[6] ^ q[2] ^ q[1];
        r[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        r[1] = q[6] ^ q[4] ^ q[1];
        r[0] = q[6] ^ q[1] ^ q[0];
        return r;
    endfunction

    function automatic logic [7:0] inv_iso_map(input logic [7:0] q);
        logic [7:0] r;
        r[7] = q[7] ^ q[6] ^ q[5] ^ q[1];
        r[6] = q[6] ^ q[2];
        r[5] = q[6] ^ q[5] ^ q[1];
        r[4] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[1];
        r[3] = q[5] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        r[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        r[1] = q[5] ^ q[4];
        r[0] = q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[0];
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] aff(input logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_aff(input logic [7:0] b);
        return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
    endfunction

    // Per lane: {h, h^l, h^2*lambda, (h^l)*l}; the inverse is h*d^-1 : (h^l)*d^-1 with d = h^2*lambda ^ (h^l)*l
    function automatic logic [15:0] stage0(input logic [1:0] mode, input logic [7:0] x);
        logic [7:0] m;
        logic [3:0] h, hl;
        m  = iso_map((mode == 2'b01) ? inv_aff(x) : x);
        h  = m[7:4];
        hl = m[7:4] ^ m[3:0];
        return {h, hl, gf4_lambda(gf4_sq(h)), gf4_mul(hl, m[3:0])};
    endfunction

    function automatic logic [7:0] stage1(input logic [15:0] v);
        logic [3:0] d_inv;
        d_inv = gf4_inv(v[7:4] ^ v[3:0]);
        return {gf4_mul(v[15:12], d_inv), gf4_mul(v[11:8], d_inv)};
    endfunction

    function automatic logic [7:0] stage2(input logic [1:0] mode, input logic [7:0] v);
        logic [7:0] y;
        y = inv_iso_map(v);
        return (mode == 2'b00) ? aff(y) : y;
    endfunction

    logic [N_LANES-1:0][15:0] s0_dat, r1_dat;
    logic [N_LANES-1:0][7:0]  s1_dat, r2_dat;
    logic [NB_DATA-1:0]       s2_dat;
    logic                     r1_vld, r2_vld;
    logic [1:0]               r1_mode, r2_mode;

    always_comb begin
        s0_dat = '0;
        s1_dat = '0;
        s2_dat = '0;
        for (int k = 0; k < N_LANES; k++) begin
            s0_dat[k]          = stage0(i_mode, i_data[8*k +: 8]);
            s1_dat[k]          = stage1(r1_dat[k]);
            s2_dat[8*k +: 8]   = stage2(r2_mode, r2_dat[k]);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r1_vld  <= 1'b0;
            r1_mode <= 2'b00;
            r1_dat  <= '0;
            r2_vld  <= 1'b0;
            r2_mode <= 2'b00;
            r2_dat  <= '0;
        end else if (i_enable) begin
            r1_vld  <= i_valid;
            r1_mode <= i_mode;
            r1_dat  <= s0_dat;
            r2_vld  <= r1_vld;
            r2_mode <= r1_mode;
            r2_dat  <= s1_dat;
        end
    end

    generate
        if (CREATE_OUTPUT_REG != 0) begin : g_out_reg
            logic               r3_vld;
            logic [1:0]         r3_mode;
            logic [NB_DATA-1:0] r3_dat;

            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    r3_vld  <= 1'b0;
                    r3_mode <= 2'b00;
                    r3_dat  <= '0;
                end else if (i_enable) begin
                    r3_vld  <= r2_vld;
                    r3_mode <= r2_mode;
                    r3_dat  <= r2_vld ? s2_dat : '0;
                end
            end

            assign o_valid = r3_vld;
            assign o_mode  = r3_mode;
            assign o_data  = r3_dat;
        end else begin : g_no_out_reg
            assign o_valid = r2_vld;
            assign o_mode  = r2_mode;
            assign o_data  = r2_vld ? s2_dat : '0;
        end
    endgenerate

endmodule

// File: tb/tb_sbox_array_pipe.sv
// Drives two instances (without / with output register) from one stimulus stream and
// scoreboards each against a polynomial-basis GF(2^8) model of the AES S-box.
module tb_sbox_array_pipe;

    localparam int NL = 16;
    localparam int ND = NL * 8;

    logic          clk = 1'b0;
    logic          rst, en, vld;
    logic [1:0]    mode;
    logic [ND-1:0] data;

    logic          o_valid0, o_valid1;
    logic [1:0]    o_mode0, o_mode1;
    logic [ND-1:0] o_data0, o_data1;

    always #5 clk = ~clk;

    sbox_array_pipe #(.N_LANES(NL), .CREATE_OUTPUT_REG(0)) dut0 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_mode(mode), .i_data(data),
        .o_valid(o_valid0), .o_mode(o_mode0), .o_data(o_data0)
    );

    sbox_array_pipe #(.N_LANES(NL), .CREATE_OUTPUT_REG(1)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_mode(mode), .i_data(data),
        .o_valid(o_valid1), .o_mode(o_mode1), .o_data(o_data1)
    );

    typedef struct {
        logic [1:0]    mode;
        logic [ND-1:0] data;
        int unsigned   issue;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          passed = 0;
    int unsigned en_cnt = 0;
    logic        last_adv = 1'b0;
    logic        last_rst = 1'b0;
    logic        mon_on = 1'b0;
    logic [130:0] prev_out [2];
    logic [7:0]  inv_tab [256];
    logic [7:0]  invaff_tab [256];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1B;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] aff_model(input logic [7:0] b);
        logic [7:0] c, r;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
        return r;
    endfunction

    function automatic logic [7:0] model_byte(input logic [1:0] m, input logic [7:0] x);
        if (m == 2'b00) return aff_model(inv_tab[x]);
        if (m == 2'b01) return inv_tab[invaff_tab[x]];
        return inv_tab[x];
    endfunction

    function automatic logic [ND-1:0] model_word(input logic [1:0] m, input logic [ND-1:0] d);
        logic [ND-1:0] r;
        r = '0;
        for (int k = 0; k < NL; k++) r[8*k +: 8] = model_byte(m, d[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [ND-1:0] rep4(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0]    b [4];
        logic [ND-1:0] r;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        r = '0;
        for (int k = 0; k < NL; k++) r[8*k +: 8] = b[k%4];
        return r;
    endfunction

    function automatic logic [ND-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver ----------------
    always @(posedge clk) begin
        last_adv = en && !rst;
        last_rst = rst;
        if (en && !rst) en_cnt++;
    end

    task automatic drive(input logic v, input logic e, input logic [1:0] m,
                         input logic [ND-1:0] d, input logic [ND-1:0] exp_d);
        exp_t x;
        vld = v; en = e; mode = m; data = d;
        if (v && e) begin
            x.mode = m; x.data = exp_d; x.issue = en_cnt;
            q0.push_back(x);
            q1.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_model(input logic v, input logic e, input logic [1:0] m, input logic [ND-1:0] d);
        drive(v, e, m, d, model_word(m, d));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 2'b00, '0, '0);
    endtask

    task automatic do_reset(input logic e);
        rst = 1'b1; en = e; vld = 1'b1; mode = 2'($urandom); data = rnd_word();
        @(posedge clk);
        q0.delete();
        q1.delete();
        mon_on = 1'b1;
        #1;
        rst = 1'b0; vld = 1'b0;
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int idx, input logic ov, input logic [1:0] om, input logic [ND-1:0] od);
        exp_t        e;
        logic        have;
        int unsigned lat;
        lat  = (idx == 0) ? 2 : 3;
        have = 1'b0;
        if (last_rst) begin
            chk($sformatf("dut%0d_reset_state", idx), {ov, om, od}, '0);
        end else if (!last_adv) begin
            chk($sformatf("dut%0d_stall_hold", idx), {ov, om, od}, prev_out[idx]);
        end else if (ov) begin
            if (idx == 0) begin
                have = (q0.size() != 0);
                if (have) e = q0.pop_front();
            end else begin
                have = (q1.size() != 0);
                if (have) e = q1.pop_front();
            end
            if (!have) begin
                chk($sformatf("dut%0d_unexpected_beat", idx), ov, 1'b0);
            end else begin
                chk($sformatf("dut%0d_data", idx), od, e.data);
                chk($sformatf("dut%0d_mode", idx), om, e.mode);
                chk($sformatf("dut%0d_latency", idx), en_cnt - e.issue, lat);
            end
        end else begin
            chk($sformatf("dut%0d_bubble_data_zero", idx), od, '0);
        end
        prev_out[idx] = {ov, om, od};
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, o_valid0, o_mode0, o_data0);
            mon(1, o_valid1, o_mode1, o_data1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [ND-1:0] d;
        rst = 1'b1; en = 1'b0; vld = 1'b0; mode = 2'b00; data = '0;

        inv_tab[0] = 8'h00;
        for (int a = 1; a < 256; a++)
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv_tab[a] = 8'(b);
        for (int x = 0; x < 256; x++) invaff_tab[aff_model(8'(x))] = 8'(x);

        @(posedge clk);
        do_reset(1'b0);

        // directed vectors, first one issued in the first cycle after reset release
        drive(1'b1, 1'b1, 2'b00, rep4(8'h00, 8'h01, 8'h53, 8'hFF), rep4(8'h63, 8'h7C, 8'hED, 8'h16));
        drive(1'b1, 1'b1, 2'b01, rep4(8'h63, 8'h7C, 8'hED, 8'h16), rep4(8'h00, 8'h01, 8'h53, 8'hFF));
        drive(1'b1, 1'b1, 2'b10, rep4(8'h53, 8'h01, 8'h00, 8'h02), rep4(8'hCA, 8'h01, 8'h00, 8'h8D));
        drive(1'b1, 1'b1, 2'b11, rep4(8'h53, 8'h01, 8'h00, 8'h02), rep4(8'hCA, 8'h01, 8'h00, 8'h8D));
        idle(4);

        // every byte value in every mode, modes interleaved beat by beat
        for (int i = 0; i < 64; i++) begin
            d = '0;
            for (int l = 0; l < NL; l++) d[8*l +: 8] = 8'((i / 4) * 16 + l);
            drive_model(1'b1, 1'b1, 2'(i % 4), d);
        end
        idle(4);

        // stall mid-flight with toggling inputs that must be ignored
        for (int i = 0; i < 3; i++) drive_model(1'b1, 1'b1, 2'($urandom), rnd_word());
        for (int i = 0; i < 4; i++) drive_model(1'($urandom), 1'b0, 2'($urandom), rnd_word());
        idle(6);

        // reset while beats are in flight, enable low
        for (int i = 0; i < 2; i++) drive_model(1'b1, 1'b1, 2'($urandom), rnd_word());
        do_reset(1'b0);
        idle(6);

        // randomized valid / enable / mode
        for (int i = 0; i < 400; i++)
            drive_model(($urandom % 4) != 0, ($urandom % 5) != 0, 2'($urandom), rnd_word());
        idle(8);

        chk("dut0_drained", 32'(q0.size()), 0);
        chk("dut1_drained", 32'(q1.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sbox_array_pipe.md
Name: sbox_array_pipe

Overview:
- Parametrised, multi-lane successor to the single-byte GF(2^8) multiplicative inversion stage.
- Processes N_LANES independent bytes per cycle through composite-field GF((2^4)^2) inversion.
- Adds selectable AES forward S-box, inverse S-box or raw-inverse mode, a valid pipeline and a global stall.
- Feeds the SubBytes stage of the AES round datapath that sits beside the GHASH core.

Parameters:
NB_BYTE, 8, byte width; only 8 supported.
N_LANES, 16, number of parallel byte lanes.
NB_DATA, N_LANES*NB_BYTE, bus width (derived; not overridden).
CREATE_OUTPUT_REG, 0, 1 = add a registered output stage (+1 cycle latency).

Ports:
i_clock  in  1  single clock; all state on rising edge
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  pipeline advance; 0 = every register holds
i_valid  in  1  input data valid; sampled only when i_enable=1
i_mode  in  2  00 fwd S-box, 01 inv S-box, 10/11 raw GF(2^8) inverse
i_data  in  NB_DATA  lane k = bits [8k+7:8k]
o_valid  out  1  output valid, aligned with o_data
o_mode  out  2  mode carried with the data
o_data  out  NB_DATA  result bytes, same lane ordering

Behaviour:
- Clock and reset: one clock, i_clock; reset i_reset is synchronous and active-high.
- Lanes are fully independent. i_mode applies to all lanes of that beat and travels down the pipe with the data, so back-to-back beats may use different modes.
- Per-lane math (polynomial x^8+x^4+x^3+x+1, composite-field isomorphic map, inverse of 0 defined as 0):
  - mode 00: out = Aff(inv(x)), where Aff is the AES affine transform with constant 0x63.
  - mode 01: out = inv(InvAff(x)), where InvAff is the inverse affine transform with constant 0x05.
  - mode 10/11: out = inv(x).
- Stage 0 (combinational):
  - InvAff is muxed in before the isomorphic map when mode=01.
  - Then: map, split high/low nibbles, square, multiply by lambda, compute the (hl·l) product.
- Register R1 captures, per lane: delta_h, delta_hl, x·lambda, prod. It also captures valid and mode.
- Stage 1: XOR the two nibble terms, take the GF(2^4) inverse, then two GF(2^4) multiplies.
- Register R2 captures the product nibbles, valid and mode.
- Stage 2 (combinational): inverse isomorphic map, then Aff muxed in when mode=00.
- If CREATE_OUTPUT_REG=1, register R3 captures the stage-2 result, valid and mode.
- Latency: exactly 2 + CREATE_OUTPUT_REG enabled cycles from i_valid to o_valid. Throughput is 1 beat per enabled cycle.
- Stall:
  - When i_enable=0, R1/R2/R3 and their valid/mode bits hold.
  - Outputs stay stable.
  - i_valid and i_data are ignored in that cycle, not queued.
- Bubbles: i_valid=0 beats propagate as o_valid=0. Data registers may load don't-care values, but o_data must read 0 whenever o_valid=0.
- Reset:
  - Clears all valid bits, mode bits and data registers to 0.
  - Reset has priority over i_enable.
  - Reset mid-flight discards every in-flight beat; no stale o_valid after reset release.
- Reset values: o_valid=0, o_mode=00, o_data=0, in both CREATE_OUTPUT_REG settings.
- In the first cycle after reset deassertion, with i_valid=1 and i_enable=1, the first result appears after exactly LATENCY enabled cycles.
- No X propagation: all registers are reset. The GF(2^4) inverse of 0 is 0.

Test Plan:
- Forward S-box, CREATE_OUTPUT_REG=0, N_LANES=16: i_mode=00, lanes = {0x00,0x01,0x53,0xFF,...}. Required: o_valid after 2 cycles; lanes = {0x63,0x7C,0xED,0x16,...}.
- Inverse S-box: i_mode=01, lanes {0x63,0x7C,0xED,0x16}. Required: {0x00,0x01,0x53,0xFF}.
- Raw inverse: i_mode=10, lanes {0x53,0x01,0x00,0x02}. Required: {0xCA,0x01,0x00,0x8D}.
- Exhaustive sweep: all 256 byte values in all modes, mixed modes back-to-back every cycle. Required: every beat matches the golden S-box/inverse table, and o_mode matches the input mode beat for beat.
- Stall, CREATE_OUTPUT_REG=1:
  - Stimulus: issue 3 beats; drop i_enable for 4 cycles mid-flight while toggling i_valid/i_data.
  - Required: outputs frozen during the stall; the 3 beats emerge in order at 3 enabled cycles each; no extra beats.
- Reset mid-flight: 2 beats in flight, assert i_reset for 1 cycle with i_enable=0. Required: next cycle o_valid=0, o_data=0, o_mode=00, and no beat emerges later.
